// File: rtl/s4ga_cfg_player.sv
// Frame store that captures one s4ga LUT-config frame from the host and replays it
// forever into the fabric's si input after holding the fabric in reset.
module s4ga_cfg_player #(
    parameter int N       = 79,
    parameter int K       = 5,
    parameter int SI_W    = 4,
    parameter int RST_CYC = N + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_valid,
    input  logic [SI_W-1:0] load_data,
    output logic            load_ready,
    input  logic            reload,
    output logic [SI_W-1:0] si,
    output logic            s4ga_rst,
    output logic            frame_start,
    output logic [7:0]      frames
);

    localparam int N_W        = $clog2(N);
    localparam int IDX_SEGS   = (N_W + SI_W - 1) / SI_W;
    localparam int MASK_SEGS  = ((1 << K) + SI_W - 1) / SI_W;
    localparam int LUT_SEGS   = K * IDX_SEGS + MASK_SEGS;
    localparam int FRAME_SEGS = N * LUT_SEGS;
    localparam int AW         = (FRAME_SEGS > 1) ? $clog2(FRAME_SEGS) : 1;
    localparam int HW         = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    localparam logic [AW-1:0] LAST_SEG  = AW'(FRAME_SEGS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYC - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_nxt;
    logic [HW-1:0]   hold_cnt;
    logic            wr_en;
    logic [SI_W-1:0] mem [FRAME_SEGS];

    // reload and rst both discard a colliding host write
    assign wr_en  = (state == LOAD) && load_valid && !reload && !rst;
    assign rd_nxt = (rd_ptr == LAST_SEG) ? '0 : rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            state       <= LOAD;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            hold_cnt    <= '0;
            si          <= '0;
            s4ga_rst    <= 1'b1;
            load_ready  <= 1'b1;
            frame_start <= 1'b0;
            frames      <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (load_valid) begin
                        if (wr_ptr == LAST_SEG) begin
                            state      <= HOLD;
                            wr_ptr     <= '0;
                            hold_cnt   <= '0;
                            load_ready <= 1'b0;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // the HOLD->RUN edge already presents segment 0
                    if (hold_cnt == HOLD_LAST) begin
                        state       <= RUN;
                        s4ga_rst    <= 1'b0;
                        si          <= mem[rd_ptr];
                        frame_start <= 1'b1;
                        rd_ptr      <= rd_nxt;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    si          <= mem[rd_ptr];
                    frame_start <= (rd_ptr == '0);
                    rd_ptr      <= rd_nxt;
                    // rd_ptr==0 here means the last segment was just presented
                    if (rd_ptr == '0)
                        frames <= frames + 8'd1;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s4ga_cfg_player.sv
// Self-checking bench for s4ga_cfg_player against a frame-level model of
// load, reset hold and cyclic replay.
module tb_s4ga_cfg_player;

    localparam int N       = 5;
    localparam int K       = 2;
    localparam int SI_W    = 4;
    localparam int RST_CYC = 6;
    localparam int FS      = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            load_valid = 1'b0;
    logic [SI_W-1:0] load_data = '0;
    logic            reload = 1'b0;
    logic            load_ready;
    logic [SI_W-1:0] si;
    logic            s4ga_rst;
    logic            frame_start;
    logic [7:0]      frames;

    int checks = 0;
    int errors = 0;

    logic [3:0] ref_mem [FS];
    logic [3:0] dat [FS];

    s4ga_cfg_player #(
        .N(N), .K(K), .SI_W(SI_W), .RST_CYC(RST_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_valid(load_valid),
        .load_data(load_data),
        .load_ready(load_ready),
        .reload(reload),
        .si(si),
        .s4ga_rst(s4ga_rst),
        .frame_start(frame_start),
        .frames(frames)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_si"}, si, 0);
        chk({tag, "_s4ga_rst"}, s4ga_rst, 1);
        chk({tag, "_load_ready"}, load_ready, 1);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_frames"}, frames, 0);
    endtask

    // Write dat[] as one frame; gap_max>0 inserts 1..gap_max idle cycles
    task automatic load_frame(input int gap_max);
        for (int i = 0; i < FS; i++) begin
            if (gap_max > 0 && i > 0) begin
                int g;
                g = $urandom_range(1, gap_max);
                load_valid = 1'b0;
                for (int k = 0; k < g; k++) begin
                    step();
                    chk("gap_load_ready", load_ready, 1);
                    chk("gap_s4ga_rst", s4ga_rst, 1);
                end
            end
            load_valid = 1'b1;
            load_data  = dat[i];
            step();
            load_valid = 1'b0;
            ref_mem[i] = dat[i];
            chk("load_ready", load_ready, (i < FS - 1) ? 1 : 0);
            chk("load_s4ga_rst", s4ga_rst, 1);
            chk("load_si", si, 0);
        end
    endtask

    // Count observed s4ga_rst=1 cycles since the final write
    task automatic wait_hold(input bit ign);
        int cnt;
        cnt = 0;
        while (s4ga_rst === 1'b1 && cnt < 40) begin
            cnt++;
            if (ign) begin
                load_valid = 1'b1;
                load_data  = 4'($urandom);
            end
            step();
        end
        load_valid = 1'b0;
        chk("hold_len", cnt, RST_CYC);
    endtask

    task automatic run_stream(input int nseg, input bit ign);
        for (int j = 0; j < nseg; j++) begin
            chk("si", si, ref_mem[j % FS]);
            chk("frame_start", frame_start, (j % FS == 0) ? 1 : 0);
            chk("frames", frames, (j / FS) % 256);
            chk("run_s4ga_rst", s4ga_rst, 0);
            if (ign) begin
                load_valid = 1'b1;
                load_data  = 4'($urandom);
            end
            step();
        end
        load_valid = 1'b0;
    endtask

    initial begin
        step();
        chk_reset_outs("rst_held");
        rst = 1'b0;
        step();
        chk_reset_outs("after_rst");

        // basic replay, then reload while 0x7 is on si
        for (int i = 0; i < FS; i++) dat[i] = 4'(i + 1);
        load_frame(0);
        wait_hold(0);
        run_stream(36, 0);
        chk("pre_reload_si", si, 7);
        reload = 1'b1;
        step();
        reload = 1'b0;
        chk_reset_outs("reload");

        for (int i = 0; i < FS; i++) dat[i] = 4'(15 - i);
        load_frame(0);
        wait_hold(0);
        run_stream(20, 0);

        // gappy load with writes ignored during HOLD and RUN
        reload = 1'b1;
        step();
        reload = 1'b0;
        chk_reset_outs("reload2");
        for (int i = 0; i < FS; i++) dat[i] = 4'(i + 1);
        load_frame(1);
        wait_hold(1);
        run_stream(40, 1);

        // reload colliding with a host write
        reload     = 1'b1;
        load_valid = 1'b1;
        load_data  = 4'hA;
        step();
        reload     = 1'b0;
        load_valid = 1'b0;
        chk_reset_outs("collide");
        for (int i = 0; i < FS; i++) dat[i] = 4'h3;
        load_frame(0);
        wait_hold(0);
        run_stream(30, 0);

        // reset mid-RUN, idle, then a random frame streamed past frames wrap
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outs("mid_rst");
        for (int c = 0; c < 20; c++) begin
            step();
            chk("idle_s4ga_rst", s4ga_rst, 1);
            chk("idle_si", si, 0);
        end
        for (int i = 0; i < FS; i++) dat[i] = 4'($urandom);
        load_frame(3);
        wait_hold(0);
        run_stream(FS * 257 + 4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/s4ga_cfg_player.md
Name: s4ga_cfg_player

Overview:
- Configuration frame store and replayer directly upstream of the s4ga LUT fabric.
- A host loads one full frame of LUT-config segments into it: N LUTs, each K input indices followed by the LUT mask, each field padded to SI_W multiples.
- It then holds the fabric in reset for more than N cycles and streams the frame into the fabric's si input, one segment per clock, repeating forever.
- The fabric has no backpressure, so the stream never stalls once running.

Parameters:
- N, 79, number of LUTs in the fabric.
- K, 5, LUT inputs.
- SI_W, 4, segment width.
- RST_CYC, N+1, fabric reset hold cycles; must be > N.
- Derived: N_W=clog2(N); IDX_SEGS=ceil(N_W/SI_W); MASK_SEGS=ceil(2**K/SI_W); LUT_SEGS=K*IDX_SEGS+MASK_SEGS; FRAME_SEGS=N*LUT_SEGS (79/5/4 gives 18 and 1422).

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- load_valid, in, 1, host segment write strobe.
- load_data, in, SI_W, host segment, frame order.
- load_ready, out, 1, high only in LOAD.
- reload, in, 1, pulse: abort and start a new load.
- si, out, SI_W, segment stream to the fabric.
- s4ga_rst, out, 1, fabric synchronous reset.
- frame_start, out, 1, pulse coincident with segment 0 of each frame on si.
- frames, out, 8, count of completed streamed frames; wraps.

Behaviour:
- Reset and clock: rst (synchronous, active-high) and clk as decided. All outputs are registered.
- Reset values: state=LOAD, wr_ptr=0, rd_ptr=0, hold_cnt=0, si=0, s4ga_rst=1, load_ready=1, frame_start=0, frames=0.
- Storage: FRAME_SEGS x SI_W memory, written by wr_ptr, read by rd_ptr.
- LOAD:
  - si=0, s4ga_rst=1.
  - load_valid=1 writes load_data to mem[wr_ptr] and increments wr_ptr.
  - The write to address FRAME_SEGS-1 moves to HOLD with hold_cnt=0 and wr_ptr=0; load_ready drops the next cycle.
  - load_valid=0 leaves everything unchanged; gaps of any length are allowed.
- HOLD:
  - s4ga_rst=1, si=0, hold_cnt increments each cycle.
  - Exactly RST_CYC cycles of s4ga_rst=1 are observed after the last load write, then RUN.
- RUN:
  - s4ga_rst=0.
  - On the first RUN cycle si=mem[0] and frame_start=1.
  - In general, the j-th RUN cycle (counting from 0) presents si=mem[j mod FRAME_SEGS].
  - frame_start=1 exactly when the presented index is 0.
  - rd_ptr wraps FRAME_SEGS-1 to 0.
  - frames increments, mod 256, in the cycle after mem[FRAME_SEGS-1] is presented.
  - No gaps or bubbles are permitted.
- load_valid outside LOAD is ignored; memory is not modified.
- reload=1 in any state, effective next cycle:
  - state=LOAD, wr_ptr=0, rd_ptr=0, frames=0, s4ga_rst=1, si=0, frame_start=0.
  - A partially streamed frame is abandoned.
  - Memory contents are retained but overwritten by the new load.
- Simultaneous events:
  - reload with load_valid in LOAD: reload wins; the data is discarded and wr_ptr=0.
  - rst with anything: rst wins.
- rst mid-RUN: outputs take reset values on the next edge; s4ga_rst=1 within 1 cycle.

Test Plan:
- Setup for all scenarios: N=5, K=2, SI_W=4, RST_CYC=6, giving N_W=3, LUT_SEGS=3, FRAME_SEGS=15.
- Basic replay:
  - Stimulus: after rst, load segments 0x1..0xF back to back.
  - Required: load_ready falls after the 15th write; s4ga_rst stays 1 for exactly 6 cycles; then si reads 1,2,...,F,1,2,... with no gaps; frame_start pulses on each 0x1; frames=1 after the first 0xF, 2 after the second.
- Gappy load:
  - Stimulus: same data with load_valid toggled 1,0,1,0.
  - Required: identical si sequence; HOLD begins only after the 15th write.
- Ignored writes:
  - Stimulus: load_valid=1 with load_data=0x0 during HOLD and RUN.
  - Required: si sequence unchanged.
- Mid-frame reload:
  - Stimulus: assert reload while si=0x7 in RUN.
  - Required: next cycle s4ga_rst=1, si=0, frames=0, load_ready=1; reloading 0xF..0x1 then streams F,E,...,1 after 6 reset cycles.
- Reload vs. load collision:
  - Stimulus: reload and load_valid in the same cycle with load_data=0xA, then 15 writes of 0x3.
  - Required: the frame is all 0x3; 0xA never appears.
- Reset mid-RUN:
  - Stimulus: rst for 1 cycle during RUN.
  - Required: s4ga_rst=1, si=0, frames=0, state LOAD; no streaming until a full 15-segment reload completes.
